// File: rtl/ram_stream_reader.sv
// Streams a contiguous, wrapping address range out of an async-read RAM
// onto a valid/ready interface, flagging the final word of each command.
module ram_stream_reader #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic [ADDRESS_WIDTH-1:0] base_addr_i,
  input  logic [ADDRESS_WIDTH:0]   len_i,
  input  logic                     abort_i,
  output logic [ADDRESS_WIDTH-1:0] ram_addr_o,
  input  logic [DATA_WIDTH-1:0]    ram_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DATA_WIDTH-1:0]    out_data_o,
  output logic                     out_last_o,
  output logic                     busy_o,
  output logic                     done_o
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  localparam logic [ADDRESS_WIDTH:0]   REM_ONE = (ADDRESS_WIDTH+1)'(1);
  localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE = ADDRESS_WIDTH'(1);
  localparam logic [ADDRESS_WIDTH:0]   LEN_ZERO = '0;

  state_t                   r_state, w_next;
  logic [ADDRESS_WIDTH-1:0] r_ptr;
  logic [ADDRESS_WIDTH:0]   r_rem;
  logic                     r_valid, r_last, r_done;
  logic [DATA_WIDTH-1:0]    r_data;

  logic w_load, w_hs, w_final, w_start, w_empty_cmd;

  // The output register refills whenever it is empty or being drained.
  assign w_load      = (r_state == S_READ) && (!r_valid || out_ready_i);
  assign w_hs        = r_valid && out_ready_i;
  assign w_final     = (r_rem == REM_ONE);
  assign w_start     = (r_state == S_IDLE) && start_i && (len_i != LEN_ZERO);
  assign w_empty_cmd = (r_state == S_IDLE) && start_i && (len_i == LEN_ZERO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (abort_i) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_start) w_next = S_READ;
        S_READ:  if (w_load && w_final) w_next = S_DRAIN;
        S_DRAIN: if (w_hs) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_rem   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
      r_done  <= 1'b0;
    end else if (abort_i) begin
      // Pointer deliberately holds so the RAM address stays where it stopped.
      r_rem   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_empty_cmd || ((r_state == S_DRAIN) && w_hs);
      if (w_start) begin
        r_ptr <= base_addr_i;
        r_rem <= len_i;
      end else if (w_load) begin
        r_data  <= ram_data_i;
        r_valid <= 1'b1;
        r_last  <= w_final;
        r_ptr   <= r_ptr + PTR_ONE;
        r_rem   <= r_rem - REM_ONE;
      end else if (w_hs) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end

  assign ram_addr_o  = r_ptr;
  assign out_valid_o = r_valid;
  assign out_data_o  = r_data;
  assign out_last_o  = r_last;
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = r_done;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader: per-cycle vector table plus
// hand-written reset, full-depth and async-reset sequences.
module tb_ram_stream_reader;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [AW:0]   len_i = '0;
  logic          abort_i = 1'b0;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_data_i;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [DW-1:0] out_data_o;
  logic          out_last_o;
  logic          busy_o;
  logic          done_o;

  logic [DW-1:0] mem [DEPTH];
  assign ram_data_i = mem[ram_addr_o];

  ram_stream_reader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
    .len_i(len_i), .abort_i(abort_i), .ram_addr_o(ram_addr_o),
    .ram_data_i(ram_data_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_last_o(out_last_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          start;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic          abort;
    logic          ready;
    logic          valid;
    logic [DW-1:0] data;
    logic          last;
    logic          busy;
    logic          done;
    logic [AW-1:0] addr;
  } vec_t;

  vec_t tbl [$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic vec_t v(input logic s, input int b, input int l,
                             input logic ab, input logic rd, input logic vl,
                             input int d, input logic ls, input logic bs,
                             input logic dn, input int ad);
    vec_t r;
    r.start = s;  r.base = AW'(b); r.len = (AW+1)'(l);
    r.abort = ab; r.ready = rd;    r.valid = vl;
    r.data = DW'(d); r.last = ls;  r.busy = bs;
    r.done = dn;  r.addr = AW'(ad);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) mem[k] = DW'(k + 100);

    // Reset state
    #3;
    check("reset_outputs", {32'(ram_addr_o), out_valid_o, out_last_o, busy_o, done_o},
          {32'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    check("reset_data", 64'(out_data_o), 64'd0);
    #10 rst_n = 1'b1;

    //          st base  len ab rd  vl data  ls bs dn addr
    tbl.push_back(v(1,   5,   4, 0, 1, 0,    0, 0, 1, 0,   5));
    tbl.push_back(v(0,   0,   0, 0, 1, 1,  105, 0, 1, 0,   6));
    tbl.push_back(v(0,   0,   0, 0, 1, 1,  106, 0, 1, 0,   7));
    tbl.push_back(v(0,   0,   0, 0, 1, 1,  107, 0, 1, 0,   8));
    tbl.push_back(v(0,   0,   0, 0, 1, 1,  108, 1, 1, 0,   9));
    tbl.push_back(v(0,   0,   0, 0, 1, 0,    0, 0, 0, 1,   9));
    tbl.push_back(v(0,   0,   0, 0, 1, 0,    0, 0, 0, 0,   9));
    // wrap, with an ignored start while busy
    tbl.push_back(v(1,1022,   4, 0, 1, 0,    0, 0, 1, 0,1022));
    tbl.push_back(v(1,  50,   2, 0, 1, 1, 1122, 0, 1, 0,1023));
    tbl.push_back(v(0,   0,   0, 0, 1, 1, 1123, 0, 1, 0,   0));
    tbl.push_back(v(0,   0,   0, 0, 1, 1,  100, 0, 1, 0,   1));
    tbl.push_back(v(0,   0,   0, 0, 1, 1,  101, 1, 1, 0,   2));
    tbl.push_back(v(0,   0,   0, 0, 1, 0,    0, 0, 0, 1,   2));
    // zero-length command
    tbl.push_back(v(1,   7,   0, 0, 1, 0,    0, 0, 0, 1,   2));
    tbl.push_back(v(0,   0,   0, 0, 1, 0,    0, 0, 0, 0,   2));
    // backpressure
    tbl.push_back(v(1,   0,   3, 0, 1, 0,    0, 0, 1, 0,   0));
    tbl.push_back(v(0,   0,   0, 0, 1, 1,  100, 0, 1, 0,   1));
    tbl.push_back(v(0,   0,   0, 0, 1, 1,  101, 0, 1, 0,   2));
    tbl.push_back(v(0,   0,   0, 0, 0, 1,  101, 0, 1, 0,   2));
    tbl.push_back(v(0,   0,   0, 0, 0, 1,  101, 0, 1, 0,   2));
    tbl.push_back(v(0,   0,   0, 0, 1, 1,  102, 1, 1, 0,   3));
    tbl.push_back(v(0,   0,   0, 0, 0, 1,  102, 1, 1, 0,   3));
    tbl.push_back(v(0,   0,   0, 0, 1, 0,    0, 0, 0, 1,   3));
    // abort while stalled after word 2 of 6
    tbl.push_back(v(1,  10,   6, 0, 0, 0,    0, 0, 1, 0,  10));
    tbl.push_back(v(0,   0,   0, 0, 0, 1,  110, 0, 1, 0,  11));
    tbl.push_back(v(0,   0,   0, 0, 1, 1,  111, 0, 1, 0,  12));
    tbl.push_back(v(0,   0,   0, 0, 0, 1,  111, 0, 1, 0,  12));
    tbl.push_back(v(0,   0,   0, 1, 0, 0,    0, 0, 0, 0,  12));
    tbl.push_back(v(1,  20,   2, 0, 1, 0,    0, 0, 1, 0,  20));
    tbl.push_back(v(0,   0,   0, 0, 1, 1,  120, 0, 1, 0,  21));
    tbl.push_back(v(0,   0,   0, 0, 1, 1,  121, 1, 1, 0,  22));
    tbl.push_back(v(0,   0,   0, 0, 1, 0,    0, 0, 0, 1,  22));
    // start in the cycle after done, len=1
    tbl.push_back(v(1,   3,   1, 0, 1, 0,    0, 0, 1, 0,   3));
    tbl.push_back(v(0,   0,   0, 0, 1, 1,  103, 1, 1, 0,   4));
    tbl.push_back(v(0,   0,   0, 0, 1, 0,    0, 0, 0, 1,   4));
    // abort beats start in IDLE
    tbl.push_back(v(1,   9,   2, 1, 1, 0,    0, 0, 0, 0,   4));
    tbl.push_back(v(0,   0,   0, 0, 1, 0,    0, 0, 0, 0,   4));

    foreach (tbl[i]) begin
      @(negedge clk);
      start_i = tbl[i].start; base_addr_i = tbl[i].base; len_i = tbl[i].len;
      abort_i = tbl[i].abort; out_ready_i = tbl[i].ready;
      @(posedge clk); #1;
      check($sformatf("vec%0d_ctl", i),
            {32'(ram_addr_o), out_valid_o, out_last_o, busy_o, done_o},
            {32'(tbl[i].addr), tbl[i].valid, tbl[i].last, tbl[i].busy, tbl[i].done});
      if (tbl[i].valid) check($sformatf("vec%0d_data", i), 64'(out_data_o), 64'(tbl[i].data));
    end

    // Full-depth read starting mid-RAM; pointer must land back on base
    begin
      int got = 0, bad = 0, cyc = 0;
      bit seen_done = 0;
      @(negedge clk);
      start_i = 1; base_addr_i = AW'(500); len_i = (AW+1)'(DEPTH); abort_i = 0; out_ready_i = 1;
      @(negedge clk);
      start_i = 0;
      while (!seen_done && cyc < DEPTH + 20) begin
        @(posedge clk); #1;
        cyc++;
        if (out_valid_o) begin
          if (out_data_o !== DW'(((500 + got) % DEPTH) + 100)) bad++;
          if (out_last_o !== (got == DEPTH - 1)) bad++;
          got++;
        end
        if (done_o) seen_done = 1;
      end
      check("full_depth_done", 64'(seen_done), 64'd1);
      check("full_depth_count", 64'(got), 64'(DEPTH));
      check("full_depth_errors", 64'(bad), 64'd0);
      check("full_depth_addr", 64'(ram_addr_o), 64'd500);
    end

    // Async reset mid-transfer, asserted between edges
    @(negedge clk);
    start_i = 1; base_addr_i = AW'(30); len_i = (AW+1)'(5); out_ready_i = 1;
    @(negedge clk); start_i = 0;
    @(posedge clk); @(posedge clk); #2;
    check("pre_reset_valid", {63'd0, out_valid_o}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset", {32'(ram_addr_o), out_valid_o, out_last_o, busy_o, done_o},
          {32'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    check("async_reset_data", 64'(out_data_o), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    start_i = 1; base_addr_i = AW'(40); len_i = (AW+1)'(2);
    @(negedge clk); start_i = 0;
    @(posedge clk); #1;
    check("post_reset_w0", {31'(out_data_o), out_valid_o, out_last_o}, {31'd140, 1'b1, 1'b0});
    @(posedge clk); #1;
    check("post_reset_w1", {31'(out_data_o), out_valid_o, out_last_o}, {31'd141, 1'b1, 1'b1});
    @(posedge clk); #1;
    check("post_reset_done", {32'(ram_addr_o), out_valid_o, busy_o, done_o},
          {32'd42, 1'b0, 1'b0, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
